// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Reader side of program_counter. It samples the PC and issues one word read
//   to instruction memory over a req/ack handshake. The returned word goes to
//   decode over a valid/ready handshake. While a fetch is in flight, stall holds
//   the PC. A redirect drops any stale fetch.
//
// Ports
//   i_clock, i_reset         rising-edge clock, synchronous active-high reset
//   i_pc                     current PC from program_counter
//   i_redirect               PC is being loaded/branched this cycle
//   o_mem_req, o_mem_addr    memory read request/address (registered)
//   i_mem_ack, i_mem_data    memory response
//   o_instr, o_instr_pc      fetched instruction and its address
//   o_instr_valid            instruction valid toward decode
//   i_instr_ready            decode accepts the instruction
//   o_stall                  PC must hold unless redirecting
//   o_fault                  sticky misaligned-PC flag
module instruction_fetch #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic                   i_redirect,
  output logic                   o_mem_req,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [INSTR_WIDTH-1:0] i_mem_data,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  output logic                   o_instr_valid,
  input  logic                   i_instr_ready,
  output logic                   o_stall,
  output logic                   o_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DISCARD} state_t;

  state_t                 r_state;
  logic                   r_mem_req;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_instr_pc;
  logic                   r_instr_valid;
  logic                   r_fault;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        // A redirect seen in IDLE means the PC on i_pc is about to change at
        // this edge. Do not sample it. Only clear the fault, and take the new
        // PC on the next cycle.
        S_IDLE: begin
          if (i_redirect) begin
            r_fault <= 1'b0;
          end else if (i_pc[1:0] != 2'b00) begin
            r_fault <= 1'b1;
          end else if (!r_fault) begin
            r_mem_addr <= i_pc;
            r_mem_req  <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            if (i_redirect) begin
              r_state <= S_IDLE;
            end else begin
              r_instr       <= i_mem_data;
              r_instr_pc    <= r_mem_addr;
              r_instr_valid <= 1'b1;
              r_state       <= S_HOLD;
            end
          end else if (i_redirect) begin
            r_state <= S_DISCARD;
          end
        end
        // Redirect and ready both release HOLD. With redirect the word is
        // simply dropped, and stall stays high, so the PC does not advance.
        S_HOLD: begin
          if (i_redirect || i_instr_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        // The request is already out, so let the memory complete it on the
        // same address. The returned word is thrown away.
        S_DISCARD: begin
          if (i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The PC advances exactly once per instruction that decode consumes.
  assign o_stall = !((r_state == S_HOLD) && i_instr_ready && !i_redirect);

  assign o_mem_req     = r_mem_req;
  assign o_mem_addr    = r_mem_addr;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_fault       = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        redirect;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        fault;

  logic ack_en;
  logic auto_pc;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Simple memory: it acks when enabled, and the data is the address plus 0xA000.
  assign mem_ack  = mem_req && ack_en;
  assign mem_data = mem_addr[31:0] + 32'hA000;

  instruction_fetch #(.ADDR_WIDTH(64), .INSTR_WIDTH(32)) dut (
    .i_clock(clk), .i_reset(rst), .i_pc(pc), .i_redirect(redirect),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack),
    .i_mem_data(mem_data), .o_instr(instr), .o_instr_pc(instr_pc),
    .o_instr_valid(instr_valid), .i_instr_ready(instr_ready),
    .o_stall(stall), .o_fault(fault)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock. The PC model advances by 4 when stall was low at the edge.
  task automatic step();
    logic adv;
    @(negedge clk);
    adv = auto_pc && !stall;
    @(posedge clk);
    #1;
    if (adv) pc = pc + 64'd4;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1 ({tag, "_req"},   mem_req, 1'b0);
    chk64({tag, "_addr"},  mem_addr, 64'h0);
    chk64({tag, "_instr"}, {32'h0, instr}, 64'h0);
    chk64({tag, "_ipc"},   instr_pc, 64'h0);
    chk1 ({tag, "_vld"},   instr_valid, 1'b0);
    chk1 ({tag, "_fault"}, fault, 1'b0);
    chk1 ({tag, "_stall"}, stall, 1'b1);
  endtask

  initial begin
    rst = 1'b1; pc = 64'h0; redirect = 1'b0; instr_ready = 1'b1;
    ack_en = 1'b1; auto_pc = 1'b0;
    step(); step();
    chk_reset_vals("rst");

    // Sequential fetch with zero-wait memory. One instruction every 3 cycles.
    rst = 1'b0; auto_pc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk1 ("seq_req",   mem_req, 1'b1);
      chk64("seq_addr",  mem_addr, 64'(4 * k));
      chk1 ("seq_vld0",  instr_valid, 1'b0);
      chk1 ("seq_stall", stall, 1'b1);
      step();
      chk1 ("seq_vld",   instr_valid, 1'b1);
      chk64("seq_ipc",   instr_pc, 64'(4 * k));
      chk64("seq_instr", {32'h0, instr}, 64'(32'hA000 + 4 * k));
      chk1 ("seq_nostall", stall, 1'b0);
      chk1 ("seq_reqlow", mem_req, 1'b0);
      step();
      chk1 ("seq_vldoff", instr_valid, 1'b0);
      chk64("seq_pcadv", pc, 64'(4 * k + 4));
    end

    // Memory wait states at 0x10: ack only in the 4th request cycle.
    auto_pc = 1'b0; pc = 64'h10; ack_en = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk1 ("ws_req",   mem_req, 1'b1);
      chk64("ws_addr",  mem_addr, 64'h10);
      chk1 ("ws_stall", stall, 1'b1);
      chk1 ("ws_vld",   instr_valid, 1'b0);
      if (i == 3) ack_en = 1'b1;
      step();
    end
    chk1 ("ws_vldon", instr_valid, 1'b1);
    chk64("ws_ipc",   instr_pc, 64'h10);
    chk64("ws_instr", {32'h0, instr}, 64'hA010);
    chk1 ("ws_stall0", stall, 1'b0);
    step();

    // Decode backpressure at 0x20 for 5 cycles.
    pc = 64'h20; instr_ready = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      chk1 ("bp_vld",   instr_valid, 1'b1);
      chk64("bp_instr", {32'h0, instr}, 64'hA020);
      chk64("bp_ipc",   instr_pc, 64'h20);
      chk1 ("bp_stall", stall, 1'b1);
      chk1 ("bp_noreq", mem_req, 1'b0);
      step();
    end
    instr_ready = 1'b1;
    #1;
    chk1("bp_release", stall, 1'b0);
    step();
    chk1("bp_vldoff", instr_valid, 1'b0);

    // Redirect in REQ at 0x30. Wait in DISCARD. The next fetch is from 0x100.
    pc = 64'h30; ack_en = 1'b0;
    step();
    chk64("rq_addr", mem_addr, 64'h30);
    redirect = 1'b1;
    step();
    pc = 64'h100;
    chk1 ("rq_disc_req",  mem_req, 1'b1);
    chk64("rq_disc_addr", mem_addr, 64'h30);
    chk1 ("rq_disc_vld",  instr_valid, 1'b0);
    chk1 ("rq_disc_stall", stall, 1'b1);
    step();  // The redirect is still high, and it has no extra effect in DISCARD.
    redirect = 1'b0;
    chk1 ("rq_disc2_req",  mem_req, 1'b1);
    chk64("rq_disc2_addr", mem_addr, 64'h30);
    ack_en = 1'b1;
    step();
    chk1("rq_drop_req", mem_req, 1'b0);
    chk1("rq_drop_vld", instr_valid, 1'b0);
    step();
    chk64("rq_new_addr", mem_addr, 64'h100);
    step();
    chk1 ("rq_new_vld",   instr_valid, 1'b1);
    chk64("rq_new_ipc",   instr_pc, 64'h100);
    chk64("rq_new_instr", {32'h0, instr}, 64'hA100);

    // Redirect in HOLD with ready=1: the word is dropped, and stall stays high.
    redirect = 1'b1;
    #1;
    chk1("rh_stall", stall, 1'b1);
    step();
    redirect = 1'b0; pc = 64'h200;
    chk1("rh_vldoff", instr_valid, 1'b0);
    chk1("rh_noreq",  mem_req, 1'b0);
    step();
    chk64("rh_addr", mem_addr, 64'h200);
    step();
    chk64("rh_ipc", instr_pc, 64'h200);
    step();

    // Misaligned PC: the fault is sticky until a redirect.
    pc = 64'h42;
    step();
    chk1("mis_fault", fault, 1'b1);
    chk1("mis_noreq", mem_req, 1'b0);
    pc = 64'h40;
    step();
    chk1("mis_sticky", fault, 1'b1);
    chk1("mis_noreq2", mem_req, 1'b0);
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    chk1("mis_clr",    fault, 1'b0);
    chk1("mis_noreq3", mem_req, 1'b0);
    ack_en = 1'b0;
    step();
    chk1 ("mis_req",  mem_req, 1'b1);
    chk64("mis_addr", mem_addr, 64'h40);

    // Reset asserted mid-REQ.
    rst = 1'b1; ack_en = 1'b1;
    step();
    chk_reset_vals("rstreq");
    rst = 1'b0;
    step();
    chk1 ("post_req",  mem_req, 1'b1);
    chk64("post_addr", mem_addr, 64'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
